// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
// rr_arbiter8_if : request/grant bundle between requesters and rr_arbiter8
// Revision 1.0
// ============================================================================
interface rr_arbiter8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output req, done,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// rr_arbiter8 : 8-way round-robin arbiter, registered one-hot grant with hold limit
// Revision 1.0
// ============================================================================
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arbiter8_if.slave  bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           state_q;
   logic [2:0]       ptr_q;
   logic [2:0]       idx_q;
   logic [7:0]       gnt_q;
   logic             valid_q;
   logic             timeout_q;
   logic [CNT_W-1:0] hold_q;

   logic [2:0]       ptr_d;
   logic [CNT_W-1:0] hold_d;
   logic             arb_hit;
   logic [2:0]       arb_idx;
   logic             rel_vol;
   logic             hold_hit;

   // Scan from ptr upward with 3-bit wrap; the first requester found wins.
   always_comb begin : p_arb
      logic [2:0] cand;
      cand    = '0;
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!arb_hit && bus.req[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
   end

   assign rel_vol  = bus.done | ~bus.req[idx_q];
   assign hold_hit = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));
   assign ptr_d    = idx_q + 3'd1;
   assign hold_d   = (&hold_q) ? hold_q : hold_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               timeout_q <= 1'b0;
               if (arb_hit) begin
                  gnt_q   <= 8'b1 << arb_idx;
                  idx_q   <= arb_idx;
                  valid_q <= 1'b1;
                  hold_q  <= CNT_W'(1);
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (rel_vol || hold_hit) begin
                  // timeout only flags a revocation the owner did not ask for
                  timeout_q <= ~rel_vol;
                  gnt_q     <= '0;
                  idx_q     <= '0;
                  valid_q   <= 1'b0;
                  ptr_q     <= ptr_d;
                  hold_q    <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  timeout_q <= 1'b0;
                  hold_q    <= hold_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// tb_rr_arbiter8 : vector table, directed corner sequences and random run
// Revision 1.0
// ============================================================================
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 16;
   localparam int CNT_W    = 5;

   logic clk;
   logic rst_n;

   rr_arbiter8_if u_if ();

   rr_arbiter8 #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: current owner (-1 = none), next-priority index, hold length
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_tmo;
   int waitc [8];

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic       tmo;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_tmo   = 1'b0;
      for (int i = 0; i < 8; i++) waitc[i] = 0;
   endtask

   task automatic model_step();
      int  w;
      int  c;
      int  mx;
      bit  vol;
      bit  lim;
      w = -1;
      if (m_owner < 0) begin
         m_tmo = 1'b0;
         for (int k = 0; k < 8; k++) begin
            c = (m_ptr + k) % 8;
            if (w < 0 && u_if.req[c]) w = c;
         end
         if (w >= 0) begin
            m_owner = w;
            m_hold  = 1;
         end
      end else begin
         vol = u_if.done || !u_if.req[m_owner];
         lim = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
         if (vol || lim) begin
            m_tmo   = !vol;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_hold  = 0;
         end else begin
            m_tmo = 1'b0;
            if (m_hold < (1 << CNT_W) - 1) m_hold++;
         end
      end
      mx = 0;
      for (int i = 0; i < 8; i++) begin
         if (!u_if.req[i])     waitc[i] = 0;
         else if (w == i)      waitc[i] = 0;
         else if (w >= 0)      waitc[i]++;
         if (waitc[i] > mx) mx = waitc[i];
      end
      if (w >= 0) chk("starvation_bound", 32'(mx <= 7), 32'd1);
   endtask

   task automatic check_model();
      logic [7:0] eg;
      eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      chk("gnt",       32'(u_if.gnt),       32'(eg));
      chk("gnt_idx",   32'(u_if.gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("gnt_valid", 32'(u_if.gnt_valid), 32'(m_owner >= 0));
      chk("timeout",   32'(u_if.timeout),   32'(m_tmo));
      chk("onehot0",   32'($onehot0(u_if.gnt)), 32'd1);
      chk("gnt_vs_idx", 32'(u_if.gnt), 32'(8'({7'b0, u_if.gnt_valid} << u_if.gnt_idx)));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_reset(input logic [7:0] r);
      rst_n     = 1'b0;
      u_if.req  = r;
      u_if.done = 1'b0;
      #2;
      model_reset();
      chk("rst_gnt",     32'(u_if.gnt),       32'd0);
      chk("rst_idx",     32'(u_if.gnt_idx),   32'd0);
      chk("rst_valid",   32'(u_if.gnt_valid), 32'd0);
      chk("rst_timeout", 32'(u_if.timeout),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      u_if.req  = '0;
      u_if.done = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         vecs[2*i]   = '{8'hFF, 1'b0, 8'(1 << i), 1'b0};
         vecs[2*i+1] = '{8'hFF, 1'b1, 8'h00,      1'b0};
      end
      vecs[16] = '{8'hFF, 1'b0, 8'h01, 1'b0};

      // Reset with all requesting, then full round-robin rotation
      do_reset(8'hFF);
      for (int i = 0; i < 17; i++) begin
         u_if.req  = vecs[i].req;
         u_if.done = vecs[i].done;
         tick();
         chk($sformatf("tbl_gnt[%0d]", i), 32'(u_if.gnt),     32'(vecs[i].gnt));
         chk($sformatf("tbl_tmo[%0d]", i), 32'(u_if.timeout), 32'(vecs[i].tmo));
      end
      chk("tbl_idx_last", 32'(u_if.gnt_idx), 32'd0);

      // Wrap past 7: reach ptr=6 via owner 5, then req 0000_0101
      do_reset(8'h20);
      tick();
      u_if.done = 1'b1; tick();
      chk("ptr6_setup", 32'(u_if.gnt), 32'h00);
      u_if.done = 1'b0; u_if.req = 8'b0000_0101; tick();
      chk("wrap_gnt", 32'(u_if.gnt), 32'h01);
      u_if.done = 1'b1; tick();
      u_if.done = 1'b0; tick();
      chk("ptr1_gnt", 32'(u_if.gnt), 32'h04);
      chk("ptr1_idx", 32'(u_if.gnt_idx), 32'd2);

      // Hold limit: 16 cycles granted, one timeout pulse, one idle, re-grant
      do_reset(8'h08);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         chk("hold_gnt", 32'(u_if.gnt), 32'h08);
         chk("hold_tmo", 32'(u_if.timeout), 32'd0);
      end
      tick();
      chk("limit_gnt", 32'(u_if.gnt), 32'h00);
      chk("limit_tmo", 32'(u_if.timeout), 32'd1);
      tick();
      chk("regrant_gnt", 32'(u_if.gnt), 32'h08);
      chk("regrant_tmo", 32'(u_if.timeout), 32'd0);

      // Owner 3 drops its request
      do_reset(8'h08);
      tick();
      u_if.req = 8'h00; tick();
      chk("drop_gnt", 32'(u_if.gnt), 32'h00);
      chk("drop_tmo", 32'(u_if.timeout), 32'd0);
      u_if.req = 8'hFF; tick();
      chk("drop_ptr4", 32'(u_if.gnt), 32'h10);

      // done coinciding with the hold limit
      do_reset(8'h08);
      for (int i = 0; i < MAX_HOLD; i++) tick();
      u_if.done = 1'b1; tick();
      chk("done_lim_gnt", 32'(u_if.gnt), 32'h00);
      chk("done_lim_tmo", 32'(u_if.timeout), 32'd0);
      u_if.done = 1'b0;

      // Async reset between edges while granted; ptr must return to 0
      do_reset(8'h04);
      tick();
      u_if.done = 1'b1; tick();
      u_if.done = 1'b0; u_if.req = 8'h20; tick();
      chk("pre_async_gnt", 32'(u_if.gnt), 32'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gnt",   32'(u_if.gnt),       32'h00);
      chk("async_valid", 32'(u_if.gnt_valid), 32'd0);
      model_reset();
      u_if.req = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("async_ptr0", 32'(u_if.gnt), 32'h01);

      // Random traffic against the model
      do_reset(8'h00);
      for (int n = 0; n < 10000; n++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 15) == 0) u_if.req[b] = ~u_if.req[b];
         if ((n / 1000) % 2 == 0) u_if.done = ($urandom_range(0, 7) == 0);
         else                     u_if.done = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
